// File: rtl/sw_array_ctrl_if.sv
// Host-side bundle of the Smith-Waterman array sequencer: job configuration,
// target-base stream and result handshake.
interface sw_array_if #(
  parameter int N_PE        = 16,
  parameter int SCORE_WIDTH = 12,
  parameter int LEN_WIDTH   = 12
);
  logic                     start;
  logic [2*N_PE-1:0]        cfg_query;
  logic [LEN_WIDTH-1:0]     cfg_len;
  logic [SCORE_WIDTH-1:0]   cfg_match;
  logic [SCORE_WIDTH-1:0]   cfg_mismatch;
  logic [SCORE_WIDTH-1:0]   cfg_gap_open;
  logic [SCORE_WIDTH-1:0]   cfg_gap_ext;
  logic                     t_valid;
  logic [1:0]               t_base;
  logic                     t_ready;
  logic                     busy;
  logic                     res_valid;
  logic                     res_ready;
  logic [SCORE_WIDTH-2:0]   res_score;
  logic                     res_err;

  modport master (
    output start, cfg_query, cfg_len, cfg_match, cfg_mismatch, cfg_gap_open, cfg_gap_ext,
           t_valid, t_base, res_ready,
    input  t_ready, busy, res_valid, res_score, res_err
  );

  modport slave (
    input  start, cfg_query, cfg_len, cfg_match, cfg_mismatch, cfg_gap_open, cfg_gap_ext,
           t_valid, t_base, res_ready,
    output t_ready, busy, res_valid, res_score, res_err
  );
endinterface

// File: rtl/sw_array_ctrl.sv
// Job sequencer for a linear systolic chain of Smith-Waterman PEs: latches the
// job, clears the array, streams target bases gap-free into PE0, waits for the
// last PE and returns the unbiased best score (or an abort flag).
module sw_array_ctrl #(
  parameter int N_PE        = 16,
  parameter int SCORE_WIDTH = 12,
  parameter int LEN_WIDTH   = 12,
  parameter int ZERO        = 2**(SCORE_WIDTH-1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  sw_array_if.slave              io_host,
  output logic                   o_pe_rst_n,
  output logic                   o_pe_en,
  output logic [1:0]             o_pe_data,
  output logic [2*N_PE-1:0]      o_pe_query,
  output logic [SCORE_WIDTH-1:0] o_pe_match,
  output logic [SCORE_WIDTH-1:0] o_pe_mismatch,
  output logic [SCORE_WIDTH-1:0] o_pe_gap_open,
  output logic [SCORE_WIDTH-1:0] o_pe_gap_ext,
  input  logic                   i_last_vld,
  input  logic [SCORE_WIDTH-1:0] i_last_high
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_ABORT  = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;
  localparam int DW = $clog2(N_PE + 5);

  logic [2:0]             r_state, w_next;
  logic [LEN_WIDTH-1:0]   r_cnt;
  logic [DW-1:0]          r_dcnt;
  logic                   r_pe_rst_n, r_pe_en, r_busy, r_res_valid, r_err;
  logic [1:0]             r_pe_data;
  logic [2*N_PE-1:0]      r_query;
  logic [SCORE_WIDTH-1:0] r_match, r_mismatch, r_gap_open, r_gap_ext;
  logic [SCORE_WIDTH-2:0] r_score, w_score;
  logic [SCORE_WIDTH-1:0] w_diff;
  logic                   w_timeout;

  // Remove the PE bias; a biased score below ZERO cannot be a local best, clamp to 0.
  assign w_diff  = i_last_high - SCORE_WIDTH'(ZERO);
  assign w_score = (i_last_high >= SCORE_WIDTH'(ZERO)) ? w_diff[SCORE_WIDTH-2:0] : '0;
  // Drain counter is only meaningful once the final beat has left PE0.
  assign w_timeout = !r_pe_en && (r_dcnt == DW'(N_PE + 3));

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (io_host.start) w_next = S_CLEAR;
      S_CLEAR:  w_next = (r_cnt == '0) ? S_RESULT : S_STREAM;
      S_STREAM: begin
        if (!io_host.t_valid)               w_next = S_ABORT;
        else if (r_cnt == LEN_WIDTH'(1))    w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_last_vld)     w_next = S_RESULT;
        else if (w_timeout) w_next = S_ABORT;
      end
      S_ABORT:  w_next = S_RESULT;
      S_RESULT: if (r_res_valid && io_host.res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State, job latches and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dcnt      <= '0;
      r_pe_rst_n  <= 1'b0;
      r_pe_en     <= 1'b0;
      r_pe_data   <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_score     <= '0;
      r_query     <= '0;
      r_match     <= '0;
      r_mismatch  <= '0;
      r_gap_open  <= '0;
      r_gap_ext   <= '0;
    end else begin
      r_state     <= w_next;
      r_pe_rst_n  <= !(w_next == S_CLEAR || w_next == S_ABORT);
      r_busy      <= (w_next != S_IDLE);
      r_res_valid <= (w_next == S_RESULT);
      r_pe_en     <= 1'b0;
      r_pe_data   <= '0;
      case (r_state)
        S_IDLE: if (io_host.start) begin
          r_query    <= io_host.cfg_query;
          r_cnt      <= io_host.cfg_len;
          r_match    <= io_host.cfg_match;
          r_mismatch <= io_host.cfg_mismatch;
          r_gap_open <= io_host.cfg_gap_open;
          r_gap_ext  <= io_host.cfg_gap_ext;
          r_err      <= 1'b0;
          r_score    <= '0;
        end
        S_STREAM: begin
          if (io_host.t_valid) begin
            r_pe_en   <= 1'b1;
            r_pe_data <= io_host.t_base;
            r_cnt     <= r_cnt - LEN_WIDTH'(1);
          end else begin
            r_err <= 1'b1;
          end
        end
        S_DRAIN: begin
          r_dcnt <= r_pe_en ? '0 : r_dcnt + DW'(1);
          if (i_last_vld)     r_score <= w_score;
          else if (w_timeout) r_err   <= 1'b1;
        end
        S_ABORT: r_score <= '0;
        default: ;
      endcase
    end
  end

  assign io_host.t_ready   = (r_state == S_STREAM);
  assign io_host.busy      = r_busy;
  assign io_host.res_valid = r_res_valid;
  assign io_host.res_score = r_score;
  assign io_host.res_err   = r_err;
  assign o_pe_rst_n    = r_pe_rst_n;
  assign o_pe_en       = r_pe_en;
  assign o_pe_data     = r_pe_data;
  assign o_pe_query    = r_query;
  assign o_pe_match    = r_match;
  assign o_pe_mismatch = r_mismatch;
  assign o_pe_gap_open = r_gap_open;
  assign o_pe_gap_ext  = r_gap_ext;
endmodule

// File: tb/tb_sw_array_ctrl.sv
// Directed bench for sw_array_ctrl with a 4-PE array; the bench plays both the
// host and the last PE, with hand-computed expected values.
module tb_sw_array_ctrl;
  localparam int NP = 4, SW = 12, LW = 12, Z = 2048;
  logic clk = 1'b0, rst = 1'b1;
  logic pe_rst_n, pe_en, last_vld;
  logic [1:0] pe_data;
  logic [2*NP-1:0] pe_query;
  logic [SW-1:0] pe_match, pe_mismatch, pe_gap_open, pe_gap_ext, last_high;
  int n_chk = 0, n_fail = 0;

  sw_array_if #(.N_PE(NP), .SCORE_WIDTH(SW), .LEN_WIDTH(LW)) hif ();

  sw_array_ctrl #(.N_PE(NP), .SCORE_WIDTH(SW), .LEN_WIDTH(LW), .ZERO(Z)) dut (
    .i_clk(clk), .i_rst(rst), .io_host(hif),
    .o_pe_rst_n(pe_rst_n), .o_pe_en(pe_en), .o_pe_data(pe_data), .o_pe_query(pe_query),
    .o_pe_match(pe_match), .o_pe_mismatch(pe_mismatch), .o_pe_gap_open(pe_gap_open),
    .o_pe_gap_ext(pe_gap_ext), .i_last_vld(last_vld), .i_last_high(last_high)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a job for one cycle; returns with the DUT in CLEAR.
  task automatic start_job(input logic [2*NP-1:0] q, input int len);
    hif.start = 1'b1; hif.cfg_query = q; hif.cfg_len = LW'(len);
    hif.cfg_match = 12'd2; hif.cfg_mismatch = 12'hFFF; hif.cfg_gap_open = 12'hFFD; hif.cfg_gap_ext = 12'hFFF;
    tick();
    hif.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_chk++; if (pe_rst_n !== 1'b0 || pe_en !== 1'b0 || pe_data !== 2'b0) begin n_fail++; $display("FAIL reset_pe: rst_n=%b en=%b data=%h want 0 0 0", pe_rst_n, pe_en, pe_data); end
    n_chk++; if (hif.t_ready !== 1'b0 || hif.busy !== 1'b0 || hif.res_valid !== 1'b0 || hif.res_err !== 1'b0 || hif.res_score !== '0) begin n_fail++; $display("FAIL reset_host: rdy=%b busy=%b vld=%b err=%b score=%0d want all 0", hif.t_ready, hif.busy, hif.res_valid, hif.res_err, hif.res_score); end
    n_chk++; if (pe_match !== '0 || pe_mismatch !== '0 || pe_gap_open !== '0 || pe_gap_ext !== '0 || pe_query !== '0) begin n_fail++; $display("FAIL reset_cfg: cfg outputs not 0 (match=%h)", pe_match); end
    rst = 1'b0; tick();
    n_chk++; if (pe_rst_n !== 1'b1) begin n_fail++; $display("FAIL idle_rst_n: got %b want 1", pe_rst_n); end
  endtask

  // AAAA query vs AAAA target: 4 matches, best = 8.
  task automatic test_match();
    start_job('0, 4);
    n_chk++; if (pe_rst_n !== 1'b0 || hif.busy !== 1'b1) begin n_fail++; $display("FAIL clear: rst_n=%b busy=%b want 0 1", pe_rst_n, hif.busy); end
    n_chk++; if (pe_match !== 12'd2 || pe_mismatch !== 12'hFFF || pe_gap_open !== 12'hFFD || pe_gap_ext !== 12'hFFF) begin n_fail++; $display("FAIL cfg_latch: %h %h %h %h want 002 fff ffd fff", pe_match, pe_mismatch, pe_gap_open, pe_gap_ext); end
    tick();
    n_chk++; if (hif.t_ready !== 1'b1 || pe_en !== 1'b0 || pe_rst_n !== 1'b1) begin n_fail++; $display("FAIL stream_entry: rdy=%b en=%b rst_n=%b want 1 0 1", hif.t_ready, pe_en, pe_rst_n); end
    hif.t_valid = 1'b1; hif.t_base = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (pe_en !== 1'b1) begin n_fail++; $display("FAIL match_en beat%0d: got %b want 1", i, pe_en); end
    end
    hif.t_valid = 1'b0;
    n_chk++; if (hif.t_ready !== 1'b0) begin n_fail++; $display("FAIL drain_rdy: got %b want 0", hif.t_ready); end
    tick();
    n_chk++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL drain_en: got %b want 0", pe_en); end
    for (int k = 0; k < NP; k++) tick();
    n_chk++; if (hif.res_valid !== 1'b0) begin n_fail++; $display("FAIL early_vld: got %b want 0", hif.res_valid); end
    last_vld = 1'b1; last_high = 12'd2056;
    tick();
    last_vld = 1'b0; last_high = '0;
    n_chk++; if (hif.res_valid !== 1'b1 || hif.res_score !== 11'd8 || hif.res_err !== 1'b0) begin n_fail++; $display("FAIL match_res: vld=%b score=%0d err=%b want 1 8 0", hif.res_valid, hif.res_score, hif.res_err); end
    hif.res_ready = 1'b1; tick(); hif.res_ready = 1'b0;
    n_chk++; if (hif.res_valid !== 1'b0 || hif.busy !== 1'b0) begin n_fail++; $display("FAIL match_ack: vld=%b busy=%b want 0 0", hif.res_valid, hif.busy); end
  endtask

  // CCCC target: no positive cell, score 0; pe_en exactly 4 cycles carrying C.
  task automatic test_mismatch();
    int en_cnt = 0, bad_data = 0;
    start_job('0, 4);
    tick();
    hif.t_valid = 1'b1; hif.t_base = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pe_en) begin en_cnt++; if (pe_data !== 2'b11) bad_data++; end
    end
    hif.t_valid = 1'b0; hif.t_base = 2'b00;
    for (int k = 0; k <= NP; k++) begin
      tick();
      if (pe_en) en_cnt++;
    end
    n_chk++; if (en_cnt != 4 || bad_data != 0) begin n_fail++; $display("FAIL mm_en: en cycles=%0d bad data=%0d want 4 0", en_cnt, bad_data); end
    last_vld = 1'b1; last_high = 12'd2048;
    tick();
    last_vld = 1'b0;
    n_chk++; if (hif.res_valid !== 1'b1 || hif.res_score !== 11'd0 || hif.res_err !== 1'b0) begin n_fail++; $display("FAIL mm_res: vld=%b score=%0d err=%b want 1 0 0", hif.res_valid, hif.res_score, hif.res_err); end
    hif.res_ready = 1'b1; tick(); hif.res_ready = 1'b0;
  endtask

  task automatic test_len0();
    start_job('0, 0);
    n_chk++; if (pe_rst_n !== 1'b0 || hif.res_valid !== 1'b0 || pe_en !== 1'b0) begin n_fail++; $display("FAIL len0_clear: rst_n=%b vld=%b en=%b want 0 0 0", pe_rst_n, hif.res_valid, pe_en); end
    tick();
    n_chk++; if (pe_rst_n !== 1'b1 || hif.res_valid !== 1'b1 || pe_en !== 1'b0) begin n_fail++; $display("FAIL len0_res: rst_n=%b vld=%b en=%b want 1 1 0", pe_rst_n, hif.res_valid, pe_en); end
    n_chk++; if (hif.res_score !== 11'd0 || hif.res_err !== 1'b0) begin n_fail++; $display("FAIL len0_score: score=%0d err=%b want 0 0", hif.res_score, hif.res_err); end
    hif.res_ready = 1'b1; tick(); hif.res_ready = 1'b0;
    n_chk++; if (hif.busy !== 1'b0) begin n_fail++; $display("FAIL len0_idle: busy=%b want 0", hif.busy); end
  endtask

  // L=6, valid dropped on the 4th beat.
  task automatic test_underflow();
    start_job('0, 6);
    tick();
    hif.t_valid = 1'b1; hif.t_base = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    n_chk++; if (pe_en !== 1'b1 || pe_data !== 2'b01) begin n_fail++; $display("FAIL uf_beats: en=%b data=%h want 1 1", pe_en, pe_data); end
    hif.t_valid = 1'b0;
    tick();
    n_chk++; if (pe_en !== 1'b0 || pe_rst_n !== 1'b0 || hif.res_err !== 1'b1 || hif.t_ready !== 1'b0) begin n_fail++; $display("FAIL uf_abort: en=%b rst_n=%b err=%b rdy=%b want 0 0 1 0", pe_en, pe_rst_n, hif.res_err, hif.t_ready); end
    tick();
    n_chk++; if (hif.res_valid !== 1'b1 || hif.res_err !== 1'b1 || hif.res_score !== 11'd0 || pe_rst_n !== 1'b1) begin n_fail++; $display("FAIL uf_res: vld=%b err=%b score=%0d rst_n=%b want 1 1 0 1", hif.res_valid, hif.res_err, hif.res_score, pe_rst_n); end
    hif.res_ready = 1'b1; tick(); hif.res_ready = 1'b0;
  endtask

  // last_vld never arrives: err exactly N_PE+4 cycles after pe_en falls; result held under backpressure.
  task automatic test_timeout();
    int bad_hold = 0;
    start_job('0, 2);
    tick();
    hif.t_valid = 1'b1; hif.t_base = 2'b10;
    tick(); tick();
    hif.t_valid = 1'b0;
    tick();
    n_chk++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL to_fall: en=%b want 0", pe_en); end
    for (int k = 1; k <= NP + 4; k++) begin
      tick();
      n_chk++; if (hif.res_err !== (k == NP + 4)) begin n_fail++; $display("FAIL to_err k=%0d: got %b want %b", k, hif.res_err, (k == NP + 4)); end
    end
    n_chk++; if (pe_rst_n !== 1'b0) begin n_fail++; $display("FAIL to_abort_rst: got %b want 0", pe_rst_n); end
    tick();
    hif.cfg_match = 12'd7; hif.start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (hif.res_valid !== 1'b1 || hif.res_err !== 1'b1 || hif.res_score !== 11'd0 || hif.busy !== 1'b1) bad_hold++;
      tick();
    end
    hif.start = 1'b0;
    n_chk++; if (bad_hold != 0 || pe_match !== 12'd2) begin n_fail++; $display("FAIL to_hold: bad cycles=%0d match=%h want 0 002", bad_hold, pe_match); end
    hif.res_ready = 1'b1; tick(); hif.res_ready = 1'b0;
    n_chk++; if (hif.res_valid !== 1'b0 || hif.busy !== 1'b0) begin n_fail++; $display("FAIL to_ack: vld=%b busy=%b want 0 0", hif.res_valid, hif.busy); end
  endtask

  task automatic test_rst_mid();
    start_job(8'hE4, 4);
    n_chk++; if (pe_query !== 8'hE4) begin n_fail++; $display("FAIL rm_query: got %h want e4", pe_query); end
    tick();
    hif.t_valid = 1'b1; hif.t_base = 2'b11;
    tick();
    hif.start = 1'b1; hif.cfg_match = 12'd5; hif.cfg_query = 8'h1B;
    tick();
    hif.start = 1'b0;
    n_chk++; if (pe_match !== 12'd2 || pe_query !== 8'hE4 || hif.t_ready !== 1'b1 || pe_en !== 1'b1) begin n_fail++; $display("FAIL rm_ignore: match=%h query=%h rdy=%b en=%b want 002 e4 1 1", pe_match, pe_query, hif.t_ready, pe_en); end
    rst = 1'b1;
    tick();
    n_chk++; if (pe_en !== 1'b0 || pe_data !== 2'b0 || pe_rst_n !== 1'b0 || hif.t_ready !== 1'b0 || hif.busy !== 1'b0 || hif.res_valid !== 1'b0) begin n_fail++; $display("FAIL rm_outs: en=%b data=%h rst_n=%b rdy=%b busy=%b vld=%b want all 0", pe_en, pe_data, pe_rst_n, hif.t_ready, hif.busy, hif.res_valid); end
    n_chk++; if (pe_match !== '0 || pe_query !== '0) begin n_fail++; $display("FAIL rm_cfg: match=%h query=%h want 0 0", pe_match, pe_query); end
    rst = 1'b0; hif.t_valid = 1'b0;
    tick(); tick();
    n_chk++; if (pe_rst_n !== 1'b1 || hif.busy !== 1'b0 || hif.t_ready !== 1'b0) begin n_fail++; $display("FAIL rm_idle: rst_n=%b busy=%b rdy=%b want 1 0 0", pe_rst_n, hif.busy, hif.t_ready); end
  endtask

  initial begin
    hif.start = 1'b0; hif.cfg_query = '0; hif.cfg_len = '0;
    hif.cfg_match = '0; hif.cfg_mismatch = '0; hif.cfg_gap_open = '0; hif.cfg_gap_ext = '0;
    hif.t_valid = 1'b0; hif.t_base = '0; hif.res_ready = 1'b0;
    last_vld = 1'b0; last_high = '0;
    test_reset();
    test_match();
    test_mismatch();
    test_len0();
    test_underflow();
    test_timeout();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
